controle_multiciclo: RTL and testbench
======================================

// Module: controle_multiciclo
// PURPOSE
//  Multicycle control unit driving the ALU and datapath: decodes the RV32I subset (add/sub/and/or/xor/sll/srl,
//  addi/ori/slli, lw/lb, sw, beq/bne) and sequences fetch/decode/execute/memory/writeback.
//  Produces estado, alusrc, alucontrol, branch, imediato (magnitude) and negativo in the encoding the ALU consumes,
//  plus register-file, memory and PC strobes. Sits between the instruction register and the ALU/memory.
// PARAMETERS
//  TIMEOUT_MEM  0  max cycles waiting for mem_pronto in a memory state; 0 = wait forever
// PORTS
//  clk          in   1   clock, rising edge
//  rst_n        in   1   reset, asynchronous, active-low
//  instrucao    in   32  instruction word; sampled only when estado==0000
//  mem_pronto   in   1   data memory done (read data valid / write committed)
//  estado       out  4   current FSM state (shared with ALU)
//  alusrc       out  1   0 = register operand, 1 = immediate/branch operation
//  alucontrol   out  4   ALU operation code
//  branch       out  1   conditional branch in progress
//  imediato     out  12  immediate magnitude
//  negativo     out  1   immediate sign (1 = subtract magnitude)
//  rs1,rs2,rd   out  5   register addresses
//  ir_write, pc_write, regwrite, memread, memwrite, memtoreg  out 1  datapath strobes
//  ilegal, erro_mem  out  1  one-cycle error pulses
// BEHAVIOUR
//  - Reset: estado=0000, every other output 0. Async assert aborts any access; memwrite/memread drop at once.
//  - States: 0000 BUSCA, 0001 DECODIFICA, 0101 EXEC (ALU ops, address calc), 0110 EXEC_DESVIO,
//    0111 LE_MEM, 1000 ESCREVE_MEM, 1001 ESCRITA_REG, 1010 DESVIO.
//  - Sequences: R/I-ALU 0000>0001>0101>1001; lw/lb 0000>0001>0101>0111>1001; sw 0000>0001>0101>1000;
//    beq/bne 0000>0001>0110>1010; then 0000. Illegal opcode/funct: 0001>0000.
//  - Strobes are Moore, decoded from the estado register only: ir_write,pc_write in 0000; memread in 0111;
//    memwrite in 1000; regwrite in 1009->only 1001; no combinational path from inputs to outputs.
//  - Decoded fields (alusrc, alucontrol, branch, imediato, negativo, rs*, rd, memtoreg) load on the 0001->next
//    edge and hold until the next 0001; branch held through 1010 so pcsrc = aluresult1 & branch is valid there.
//  - alucontrol: add 0010, sub 0110, and 0000, or 0001, xor 0100, sll/slli 1010, srl 0101, addi 0011,
//    ori 1001, lw/sw 0010, lb 1100, beq 1111, bne 0110. alusrc=1 for all I/S/B forms, 0 for R.
//  - Immediate: sign-extended value v. negativo=v<0; imediato=|v| (12-bit, -2048 -> 0x800).
//    lw/sw give byte offset (ALU divides by 4). slli: imediato={7'b0,shamt}, negativo=0.
//    ori: imediato=instr[31:20] raw, negativo=0 (ALU zero-extends). Branch: imediato=|offset|>>1 (halfwords).
//  - memtoreg=1 for lw/lb, 0 otherwise.
//  - 0111/1000 stay until mem_pronto=1 (sampled each cycle, incl. first). TIMEOUT_MEM>0: cycle counter clears
//    on entry; at TIMEOUT_MEM cycles without mem_pronto go to 0000, erro_mem=1 one cycle, no regwrite.
//  - ilegal: registered pulse, high for the single BUSCA cycle after an illegal decode; no regwrite/memwrite issued.
//  - mem_pronto outside 0111/1000 ignored. instrucao changes outside 0000 ignored.
// TESTING
//  1. instrucao=0x002081B3 (add x3,x1,x2) -> estado 0000,0001,0101,1001,0000; alucontrol=0010, alusrc=0,
//     rs1=1 rs2=2 rd=3, regwrite=1 only in 1001.
//  2. 0xFFC00293 (addi x5,x0,-4) -> alucontrol=0011, alusrc=1, negativo=1, imediato=0x004.
//  3. 0x00812303 (lw x6,8(x2)), mem_pronto low 3 cycles -> 0111 for 4 cycles, memread held, then 1001
//     memtoreg=1, imediato=0x008 negativo=0.
//  4. 0xFE209CE3 (bne x1,x2,-8) -> estado 0110 then 1010, alucontrol=0110, branch=1 through 1010,
//     negativo=1, imediato=0x004.
//  5. 0x0000007F -> 0001>0000, ilegal=1 one cycle, regwrite/memwrite never asserted.
//  6. sw in 1000, memwrite=1, rst_n low mid-cycle -> memwrite=0 and estado=0000 without clock edge;
//     TIMEOUT_MEM=4, mem_pronto stuck 0 -> erro_mem pulse after 4 cycles, estado 0000.

Source files
------------

// File: rtl/controle_multiciclo.sv
// Multicycle control unit for an RV32I subset: sequences fetch/decode/execute/memory/writeback
// and presents the ALU its operation code plus the immediate in sign/magnitude form.
module controle_multiciclo #(
    parameter int TIMEOUT_MEM = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instrucao,
    input  logic        mem_pronto,
    output logic [3:0]  estado,
    output logic        alusrc,
    output logic [3:0]  alucontrol,
    output logic        branch,
    output logic [11:0] imediato,
    output logic        negativo,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic        ir_write,
    output logic        pc_write,
    output logic        regwrite,
    output logic        memread,
    output logic        memwrite,
    output logic        memtoreg,
    output logic        ilegal,
    output logic        erro_mem
);

    typedef enum logic [3:0] {
        BUSCA       = 4'b0000,
        DECODIFICA  = 4'b0001,
        EXEC        = 4'b0101,
        EXEC_DESVIO = 4'b0110,
        LE_MEM      = 4'b0111,
        ESCREVE_MEM = 4'b1000,
        ESCRITA_REG = 4'b1001,
        DESVIO      = 4'b1010
    } estado_t;

    typedef enum logic [1:0] {
        C_ALU    = 2'd0,
        C_LOAD   = 2'd1,
        C_STORE  = 2'd2,
        C_BRANCH = 2'd3
    } classe_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    localparam int                CNT_W    = (TIMEOUT_MEM > 1) ? $clog2(TIMEOUT_MEM) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_MEM - 1);

    // Returns {sign, |v|}; the most negative value maps to magnitude 0x800.
    function automatic logic [12:0] sinal_magnitude(input logic signed [11:0] v);
        logic [11:0] mag;
        mag = v[11] ? 12'(-v) : 12'(v);
        return {v[11], mag};
    endfunction

    estado_t          estado_q;
    classe_t          classe_q;
    logic             ativo_q;
    logic [31:0]      ir_q;
    logic [CNT_W-1:0] cnt_q;
    logic             alusrc_q;
    logic [3:0]       aluctl_q;
    logic             branch_q;
    logic [11:0]      imm_q;
    logic             neg_q;
    logic [4:0]       rs1_q;
    logic [4:0]       rs2_q;
    logic [4:0]       rd_q;
    logic             memtoreg_q;
    logic             ilegal_q;
    logic             erro_mem_q;

    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic signed [11:0] imm_i;
    logic signed [11:0] imm_s;
    logic signed [11:0] imm_b;

    assign opcode = ir_q[6:0];
    assign funct3 = ir_q[14:12];
    assign funct7 = ir_q[31:25];
    assign imm_i  = ir_q[31:20];
    assign imm_s  = {ir_q[31:25], ir_q[11:7]};
    // Branch offset is always even, so the halfword count is the B-field without its implicit zero.
    assign imm_b  = {ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8]};

    logic       legal_d;
    classe_t    classe_d;
    logic       alusrc_d;
    logic [3:0] aluctl_d;
    logic       branch_d;
    logic       memtoreg_d;
    logic [11:0] imm_d;
    logic       neg_d;

    always_comb begin
        legal_d    = 1'b0;
        classe_d   = C_ALU;
        alusrc_d   = 1'b1;
        aluctl_d   = 4'b0000;
        branch_d   = 1'b0;
        memtoreg_d = 1'b0;
        imm_d      = 12'd0;
        neg_d      = 1'b0;
        case (opcode)
            OP_R: begin
                alusrc_d = 1'b0;
                legal_d  = 1'b1;
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        3'b000:  aluctl_d = 4'b0010;
                        3'b001:  aluctl_d = 4'b1010;
                        3'b100:  aluctl_d = 4'b0100;
                        3'b101:  aluctl_d = 4'b0101;
                        3'b110:  aluctl_d = 4'b0001;
                        3'b111:  aluctl_d = 4'b0000;
                        default: legal_d  = 1'b0;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    aluctl_d = 4'b0110;
                end else begin
                    legal_d = 1'b0;
                end
            end
            OP_IMM: begin
                legal_d = 1'b1;
                case (funct3)
                    3'b000: begin
                        aluctl_d       = 4'b0011;
                        {neg_d, imm_d} = sinal_magnitude(imm_i);
                    end
                    // ori hands over the raw field; the ALU zero-extends it
                    3'b110: begin
                        aluctl_d = 4'b1001;
                        imm_d    = ir_q[31:20];
                    end
                    3'b001: begin
                        aluctl_d = 4'b1010;
                        imm_d    = {7'b0, ir_q[24:20]};
                        legal_d  = (funct7 == F7_BASE);
                    end
                    default: legal_d = 1'b0;
                endcase
            end
            OP_LOAD: begin
                classe_d       = C_LOAD;
                memtoreg_d     = 1'b1;
                {neg_d, imm_d} = sinal_magnitude(imm_i);
                case (funct3)
                    3'b010: begin
                        legal_d  = 1'b1;
                        aluctl_d = 4'b0010;
                    end
                    3'b000: begin
                        legal_d  = 1'b1;
                        aluctl_d = 4'b1100;
                    end
                    default: legal_d = 1'b0;
                endcase
            end
            OP_STORE: begin
                classe_d       = C_STORE;
                aluctl_d       = 4'b0010;
                legal_d        = (funct3 == 3'b010);
                {neg_d, imm_d} = sinal_magnitude(imm_s);
            end
            OP_BRANCH: begin
                classe_d       = C_BRANCH;
                branch_d       = 1'b1;
                {neg_d, imm_d} = sinal_magnitude(imm_b);
                case (funct3)
                    3'b000: begin
                        legal_d  = 1'b1;
                        aluctl_d = 4'b1111;
                    end
                    3'b001: begin
                        legal_d  = 1'b1;
                        aluctl_d = 4'b0110;
                    end
                    default: legal_d = 1'b0;
                endcase
            end
            default: legal_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q   <= BUSCA;
            classe_q   <= C_ALU;
            ativo_q    <= 1'b0;
            ir_q       <= '0;
            cnt_q      <= '0;
            alusrc_q   <= 1'b0;
            aluctl_q   <= 4'b0000;
            branch_q   <= 1'b0;
            imm_q      <= 12'd0;
            neg_q      <= 1'b0;
            rs1_q      <= 5'd0;
            rs2_q      <= 5'd0;
            rd_q       <= 5'd0;
            memtoreg_q <= 1'b0;
            ilegal_q   <= 1'b0;
            erro_mem_q <= 1'b0;
        end else begin
            ilegal_q   <= 1'b0;
            erro_mem_q <= 1'b0;
            case (estado_q)
                // First edge after reset only arms the unit, so reset leaves every output low.
                BUSCA: begin
                    if (!ativo_q) begin
                        ativo_q <= 1'b1;
                    end else begin
                        ir_q     <= instrucao;
                        estado_q <= DECODIFICA;
                    end
                end
                DECODIFICA: begin
                    if (legal_d) begin
                        classe_q   <= classe_d;
                        alusrc_q   <= alusrc_d;
                        aluctl_q   <= aluctl_d;
                        branch_q   <= branch_d;
                        imm_q      <= imm_d;
                        neg_q      <= neg_d;
                        rs1_q      <= ir_q[19:15];
                        rs2_q      <= ir_q[24:20];
                        rd_q       <= ir_q[11:7];
                        memtoreg_q <= memtoreg_d;
                        estado_q   <= (classe_d == C_BRANCH) ? EXEC_DESVIO : EXEC;
                    end else begin
                        ilegal_q <= 1'b1;
                        estado_q <= BUSCA;
                    end
                end
                EXEC: begin
                    cnt_q <= '0;
                    case (classe_q)
                        C_LOAD:  estado_q <= LE_MEM;
                        C_STORE: estado_q <= ESCREVE_MEM;
                        default: estado_q <= ESCRITA_REG;
                    endcase
                end
                LE_MEM, ESCREVE_MEM: begin
                    if (mem_pronto) begin
                        estado_q <= (estado_q == LE_MEM) ? ESCRITA_REG : BUSCA;
                    end else if (TIMEOUT_MEM > 0 && cnt_q == CNT_LAST) begin
                        erro_mem_q <= 1'b1;
                        estado_q   <= BUSCA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                EXEC_DESVIO: estado_q <= DESVIO;
                default:     estado_q <= BUSCA;
            endcase
        end
    end

    // Strobes depend on the state register alone; reset clears them without waiting for a clock.
    assign ir_write   = (estado_q == BUSCA) && ativo_q;
    assign pc_write   = (estado_q == BUSCA) && ativo_q;
    assign memread    = (estado_q == LE_MEM);
    assign memwrite   = (estado_q == ESCREVE_MEM);
    assign regwrite   = (estado_q == ESCRITA_REG);

    assign estado     = estado_q;
    assign alusrc     = alusrc_q;
    assign alucontrol = aluctl_q;
    assign branch     = branch_q;
    assign imediato   = imm_q;
    assign negativo   = neg_q;
    assign rs1        = rs1_q;
    assign rs2        = rs2_q;
    assign rd         = rd_q;
    assign memtoreg   = memtoreg_q;
    assign ilegal     = ilegal_q;
    assign erro_mem   = erro_mem_q;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Bench for controle_multiciclo: directed vector table, asynchronous-reset sequence and
// randomized instructions checked against a mnemonic-level reference model.
module tb_controle_multiciclo;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instrucao = 32'd0;
    logic        mem_pronto = 1'b0;
    logic [3:0]  estado;
    logic        alusrc;
    logic [3:0]  alucontrol;
    logic        branch;
    logic [11:0] imediato;
    logic        negativo;
    logic [4:0]  rs1, rs2, rd;
    logic        ir_write, pc_write, regwrite, memread, memwrite, memtoreg;
    logic        ilegal, erro_mem;

    controle_multiciclo #(.TIMEOUT_MEM(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .instrucao(instrucao), .mem_pronto(mem_pronto),
        .estado(estado), .alusrc(alusrc), .alucontrol(alucontrol), .branch(branch),
        .imediato(imediato), .negativo(negativo), .rs1(rs1), .rs2(rs2), .rd(rd),
        .ir_write(ir_write), .pc_write(pc_write), .regwrite(regwrite), .memread(memread),
        .memwrite(memwrite), .memtoreg(memtoreg), .ilegal(ilegal), .erro_mem(erro_mem)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        legal;
        logic [1:0]  cls;        // 0 alu, 1 load, 2 store, 3 branch
        logic [3:0]  alucontrol;
        logic        alusrc;
        logic        branch;
        logic [11:0] imediato;
        logic        negativo;
        logic        memtoreg;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        int          delay;
        exp_t        e;
    } vec_t;

    int checks = 0;
    int errors = 0;
    bit pend_ilegal = 1'b0;
    bit pend_erro = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t mk(input logic legal, input logic [1:0] cls, input logic [3:0] alu,
                                input logic src, input logic br, input logic [11:0] imm,
                                input logic neg, input logic m2r, input logic [4:0] a,
                                input logic [4:0] b, input logic [4:0] d);
        exp_t e;
        e = '{legal, cls, alu, src, br, imm, neg, m2r, a, b, d};
        return e;
    endfunction

    // Reference: name the instruction, then derive its ALU code and signed immediate value.
    function automatic exp_t ref_decode(input logic [31:0] w);
        exp_t       e;
        string      m;
        int         v;
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = w[14:12];
        f7 = w[31:25];
        m  = "";
        v  = 0;
        e  = '0;
        e.rs1 = w[19:15];
        e.rs2 = w[24:20];
        e.rd  = w[11:7];
        case (w[6:0])
            7'h33: begin
                if (f7 == 7'h00) begin
                    case (f3)
                        3'd0: m = "add";
                        3'd1: m = "sll";
                        3'd4: m = "xor";
                        3'd5: m = "srl";
                        3'd6: m = "or";
                        3'd7: m = "and";
                        default: m = "";
                    endcase
                end else if (f7 == 7'h20 && f3 == 3'd0) m = "sub";
            end
            7'h13: begin
                if (f3 == 3'd0) m = "addi";
                else if (f3 == 3'd6) m = "ori";
                else if (f3 == 3'd1 && f7 == 7'h00) m = "slli";
            end
            7'h03: begin
                if (f3 == 3'd2) m = "lw";
                else if (f3 == 3'd0) m = "lb";
            end
            7'h23: if (f3 == 3'd2) m = "sw";
            7'h63: begin
                if (f3 == 3'd0) m = "beq";
                else if (f3 == 3'd1) m = "bne";
            end
            default: m = "";
        endcase
        e.legal  = (m != "");
        e.alusrc = e.legal;
        case (m)
            "add": begin e.alucontrol = 4'b0010; e.alusrc = 1'b0; end
            "sub": begin e.alucontrol = 4'b0110; e.alusrc = 1'b0; end
            "and": begin e.alucontrol = 4'b0000; e.alusrc = 1'b0; end
            "or":  begin e.alucontrol = 4'b0001; e.alusrc = 1'b0; end
            "xor": begin e.alucontrol = 4'b0100; e.alusrc = 1'b0; end
            "sll": begin e.alucontrol = 4'b1010; e.alusrc = 1'b0; end
            "srl": begin e.alucontrol = 4'b0101; e.alusrc = 1'b0; end
            "addi": begin e.alucontrol = 4'b0011; v = int'($signed(w[31:20])); end
            "ori":  begin e.alucontrol = 4'b1001; v = int'(w[31:20]); end
            "slli": begin e.alucontrol = 4'b1010; v = int'(w[24:20]); end
            "lw": begin e.alucontrol = 4'b0010; e.cls = 2'd1; e.memtoreg = 1'b1; v = int'($signed(w[31:20])); end
            "lb": begin e.alucontrol = 4'b1100; e.cls = 2'd1; e.memtoreg = 1'b1; v = int'($signed(w[31:20])); end
            "sw": begin e.alucontrol = 4'b0010; e.cls = 2'd2; v = int'($signed({w[31:25], w[11:7]})); end
            "beq", "bne": begin
                e.alucontrol = (m == "beq") ? 4'b1111 : 4'b0110;
                e.cls    = 2'd3;
                e.branch = 1'b1;
                v = int'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0})) / 2;
            end
            default: e.alucontrol = 4'b0000;
        endcase
        e.negativo = (v < 0);
        e.imediato = 12'(v < 0 ? -v : v);
        return e;
    endfunction

    // Runs one instruction from an armed BUSCA cycle through to the next BUSCA, checking every cycle.
    task automatic run_instr(input logic [31:0] w, input int delay, input exp_t e);
        logic [3:0] seq[$];
        logic [3:0] st;
        logic [3:0] mst;
        int         k;
        bit         tmo;
        seq = {4'h0, 4'h1};
        tmo = 1'b0;
        k   = 0;
        if (e.legal) begin
            case (e.cls)
                2'd0: seq = {seq, 4'h5, 4'h9};
                2'd3: seq = {seq, 4'h6, 4'hA};
                default: begin
                    mst = (e.cls == 2'd1) ? 4'h7 : 4'h8;
                    seq.push_back(4'h5);
                    tmo = (delay >= TMO);
                    for (int n = 0; n < (tmo ? TMO : delay + 1); n++) seq.push_back(mst);
                    if (!tmo && e.cls == 2'd1) seq.push_back(4'h9);
                end
            endcase
        end
        instrucao = w;
        for (int i = 0; i < seq.size(); i++) begin
            st = seq[i];
            chk("estado", {28'd0, estado}, {28'd0, st});
            chk("strobes", {27'd0, ir_write, pc_write, memread, memwrite, regwrite},
                {27'd0, st == 4'h0, st == 4'h0, st == 4'h7, st == 4'h8, st == 4'h9});
            chk("ilegal", {31'd0, ilegal}, {31'd0, (i == 0) && pend_ilegal});
            chk("erro_mem", {31'd0, erro_mem}, {31'd0, (i == 0) && pend_erro});
            if (i >= 2) begin
                chk("alucontrol", {28'd0, alucontrol}, {28'd0, e.alucontrol});
                chk("alusrc_branch_memtoreg", {29'd0, alusrc, branch, memtoreg},
                    {29'd0, e.alusrc, e.branch, e.memtoreg});
                chk("imediato", {19'd0, negativo, imediato}, {19'd0, e.negativo, e.imediato});
                chk("regs", {17'd0, rs1, rs2, rd}, {17'd0, e.rs1, e.rs2, e.rd});
            end
            if (st == 4'h7 || st == 4'h8) begin
                mem_pronto = (k == delay);
                k++;
            end else begin
                mem_pronto = 1'($urandom_range(0, 1));
            end
            if (i > 0) instrucao = $urandom;
            step();
        end
        pend_ilegal = !e.legal;
        pend_erro   = tmo;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_estado"}, {28'd0, estado}, 32'd0);
        chk({tag, "_fields"}, {13'd0, alusrc, alucontrol, branch, imediato, negativo}, 32'd0);
        chk({tag, "_regs"}, {17'd0, rs1, rs2, rd}, 32'd0);
        chk({tag, "_strobes"}, {24'd0, ir_write, pc_write, regwrite, memread, memwrite, memtoreg,
            ilegal, erro_mem}, 32'd0);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int          r;
        w = $urandom;
        case ($urandom_range(0, 5))
            0: w[6:0] = 7'h33;
            1: w[6:0] = 7'h13;
            2: w[6:0] = 7'h03;
            3: w[6:0] = 7'h23;
            4: w[6:0] = 7'h63;
            default: w[6:0] = 7'($urandom);
        endcase
        r = $urandom_range(0, 3);
        if (w[6:0] == 7'h33 || (w[6:0] == 7'h13 && w[14:12] == 3'd1)) begin
            if (r < 2) w[31:25] = 7'h00;
            else if (r == 2) w[31:25] = 7'h20;
        end
        return w;
    endfunction

    vec_t vecs[10];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        vecs[0] = '{32'h002081B3, 0, mk(1, 0, 4'b0010, 0, 0, 12'h000, 0, 0, 1, 2, 3)};
        vecs[1] = '{32'hFFC00293, 0, mk(1, 0, 4'b0011, 1, 0, 12'h004, 1, 0, 0, 28, 5)};
        vecs[2] = '{32'h00812303, 3, mk(1, 1, 4'b0010, 1, 0, 12'h008, 0, 1, 2, 8, 6)};
        vecs[3] = '{32'hFE209CE3, 0, mk(1, 3, 4'b0110, 1, 1, 12'h004, 1, 0, 1, 2, 25)};
        vecs[4] = '{32'h0000007F, 0, mk(0, 0, 4'b0000, 0, 0, 12'h000, 0, 0, 0, 0, 0)};
        vecs[5] = '{32'h8050A023, 1, mk(1, 2, 4'b0010, 1, 0, 12'h800, 1, 0, 1, 5, 0)};
        vecs[6] = '{32'hFFF18383, 5, mk(1, 1, 4'b1100, 1, 0, 12'h001, 1, 1, 3, 31, 7)};
        vecs[7] = '{32'hFFF16093, 0, mk(1, 0, 4'b1001, 1, 0, 12'hFFF, 0, 0, 2, 31, 1)};
        vecs[8] = '{32'h01F21213, 0, mk(1, 0, 4'b1010, 1, 0, 12'h01F, 0, 0, 4, 31, 4)};
        vecs[9] = '{32'h80208063, 0, mk(1, 3, 4'b1111, 1, 1, 12'h800, 1, 0, 1, 2, 0)};

        rst_n = 1'b0;
        step();
        step();
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        chk("idle_after_reset", {30'd0, ir_write, pc_write}, 32'd0);
        step();

        for (int i = 0; i < 10; i++) run_instr(vecs[i].instr, vecs[i].delay, vecs[i].e);

        // Asynchronous reset in the middle of a store must drop memwrite immediately.
        instrucao  = 32'h8050A023;
        mem_pronto = 1'b0;
        for (int n = 0; n < 8 && estado != 4'h8; n++) begin
            step();
            if (estado != 4'h0) instrucao = $urandom;
        end
        chk("rst_reach_1000", {28'd0, estado}, 32'd8);
        chk("rst_memwrite_before", {31'd0, memwrite}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_memwrite_async", {31'd0, memwrite}, 32'd0);
        chk_reset_outputs("rst_async");
        step();
        rst_n = 1'b1;
        pend_ilegal = 1'b0;
        pend_erro   = 1'b0;
        chk("idle_after_rst_async", {30'd0, ir_write, pc_write}, 32'd0);
        step();

        for (int i = 0; i < 200; i++) begin
            logic [31:0] w;
            w = rand_instr();
            run_instr(w, $urandom_range(0, 6), ref_decode(w));
        end
        run_instr(32'h002081B3, 0, ref_decode(32'h002081B3));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
